// File: rtl/ecc_pkg.sv
// Shared SECDED helpers: check-bit count, codeword position <-> data index
// mapping, and the error class reported by the decoder.
package ecc_pkg;

   typedef enum logic [1:0] {ECC_OK, ECC_SE, ECC_DE} ecc_err_e;

   // Smallest m with 2^m >= m + k + 1.
   function automatic int calculate_m(input int k);
      int m;
      m = 1;
      while ((1 << m) < (m + k + 1)) m++;
      return m;
   endfunction

   function automatic int floor_log2(input int v);
      int r;
      r = 0;
      for (int b = 0; b < 31; b++)
         if ((v >> b) != 0) r = b;
      return r;
   endfunction

   // Hamming position (1-based) of data bit idx; power-of-2 positions hold parity.
   function automatic int data_pos(input int idx);
      int cnt;
      int res;
      cnt = 0;
      res = 0;
      for (int p = 3; p < 4096; p++) begin
         if ((p & (p - 1)) != 0) begin
            if (cnt == idx && res == 0) res = p;
            cnt++;
         end
      end
      return res;
   endfunction

   // Data index held at a Hamming position, -1 for parity positions.
   function automatic int pos_to_didx(input int pos);
      if (pos <= 0 || (pos & (pos - 1)) == 0) return -1;
      return pos - floor_log2(pos) - 2;
   endfunction

   // Bit index in the stored word for a position; position 0 is the overall parity p0.
   function automatic int cw_idx(input int pos, input int n, input bit p0_lsb);
      if (pos == 0) return p0_lsb ? 0 : n;
      return p0_lsb ? pos : pos - 1;
   endfunction

endpackage

// File: rtl/ecc_syndrome.sv
// Combinational syndrome and overall parity of an extended-Hamming codeword.
module ecc_syndrome
   import ecc_pkg::*;
#(
   parameter int K      = 32,
   parameter bit P0_LSB = 1'b1,
   localparam int M     = calculate_m(K),
   localparam int N     = M + K
) (
   input  logic [N:0]   cw,
   output logic [M-1:0] s,
   output logic         pe
);

   always_comb begin
      s = '0;
      for (int i = 1; i <= N; i++)
         if (cw[cw_idx(i, N, P0_LSB)]) s = s ^ M'(i);
   end

   assign pe = ^cw;

endmodule

// File: rtl/ecc_dec_stage.sv
// Two-stage SECDED decoder with valid/ready on both sides and saturating
// single/double error counters.
module ecc_dec_stage
   import ecc_pkg::*;
#(
   parameter int K      = 32,
   parameter bit P0_LSB = 1'b1,
   parameter int CNT_W  = 16,
   localparam int M     = calculate_m(K),
   localparam int N     = M + K
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [N:0]       cw_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [K-1:0]     data_o,
   output logic             se_o,
   output logic             de_o,
   output logic [M-1:0]     syndrome_o,
   input  logic             clr_cnt_i,
   output logic [CNT_W-1:0] se_cnt_o,
   output logic [CNT_W-1:0] de_cnt_o
);

   localparam int STAGES = 2;

   logic [STAGES:1] vld_pipe;
   logic            s2_can_load, s1_adv, in_fire, out_fire;

   logic [M-1:0]    syn_c;
   logic            pe_c;

   logic [N:0]      s1_cw;
   logic [M-1:0]    s1_syn;
   logic            s1_pe;

   logic [N:1]      pos_v, fix_v;
   logic [K-1:0]    dat_c;
   logic            do_fix;
   ecc_err_e        err_c;

   // Handshake: S2 frees up on its own transfer, S1 frees up when it moves to S2.
   assign s2_can_load = !vld_pipe[2] | out_ready_i;
   assign s1_adv      = vld_pipe[1] & s2_can_load;
   assign in_ready_o  = !vld_pipe[1] | s2_can_load;
   assign in_fire     = in_valid_i & in_ready_o;
   assign out_fire    = vld_pipe[2] & out_ready_i;
   assign out_valid_o = vld_pipe[2];

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         vld_pipe <= '0;
      end else begin
         if (in_ready_o)  vld_pipe[1] <= in_valid_i;
         if (s2_can_load) vld_pipe[2] <= vld_pipe[1];
      end
   end

   ecc_syndrome #(.K(K), .P0_LSB(P0_LSB)) u_syn (
      .cw (cw_i),
      .s  (syn_c),
      .pe (pe_c)
   );

   // S1: codeword plus its syndrome/parity.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_cw  <= '0;
         s1_syn <= '0;
         s1_pe  <= 1'b0;
      end else if (in_fire) begin
         s1_cw  <= cw_i;
         s1_syn <= syn_c;
         s1_pe  <= pe_c;
      end
   end

   // Correction only for an odd-weight error pointing inside the word.
   assign do_fix = s1_pe && (s1_syn != '0) && (s1_syn <= M'(N));

   always_comb begin
      pos_v = '0;
      for (int i = 1; i <= N; i++)
         pos_v[i] = s1_cw[cw_idx(i, N, P0_LSB)];
      fix_v = pos_v;
      for (int i = 1; i <= N; i++)
         if (do_fix && (s1_syn == M'(i))) fix_v[i] = ~pos_v[i];
      dat_c = '0;
      for (int k = 0; k < K; k++)
         dat_c[k] = fix_v[data_pos(k)];
   end

   always_comb begin
      err_c = ECC_OK;
      if (s1_pe) err_c = (s1_syn <= M'(N)) ? ECC_SE : ECC_DE;
      else if (s1_syn != '0) err_c = ECC_DE;
   end

   // S2: result registers, held while the consumer stalls.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         data_o     <= '0;
         se_o       <= 1'b0;
         de_o       <= 1'b0;
         syndrome_o <= '0;
      end else if (s1_adv) begin
         data_o     <= dat_c;
         se_o       <= (err_c == ECC_SE);
         de_o       <= (err_c == ECC_DE);
         syndrome_o <= s1_syn;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n || clr_cnt_i) begin
         se_cnt_o <= '0;
         de_cnt_o <= '0;
      end else if (out_fire) begin
         if (se_o && (se_cnt_o != '1)) se_cnt_o <= se_cnt_o + 1'b1;
         if (de_o && (de_cnt_o != '1)) de_cnt_o <= de_cnt_o + 1'b1;
      end
   end

endmodule

// File: tb/tb_ecc_dec_stage.sv
// Directed bench for ecc_dec_stage: vector table, backpressure stream,
// counter clear/saturation and reset with words in flight.
module tb_ecc_dec_stage;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        in_valid, in_ready, out_valid, out_ready, se, de, clr;
   logic [38:0] cw;
   logic [31:0] data;
   logic [5:0]  syn;
   logic [15:0] se_cnt, de_cnt;

   logic        in_valid2, in_ready2, out_valid2, out_ready2, se2, de2;
   logic [38:0] cw2;
   logic [31:0] data2;
   logic [5:0]  syn2;
   logic [1:0]  se_cnt2, de_cnt2;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   ecc_dec_stage #(.K(32), .P0_LSB(1'b1), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
      .cw_i(cw), .out_valid_o(out_valid), .out_ready_i(out_ready),
      .data_o(data), .se_o(se), .de_o(de), .syndrome_o(syn),
      .clr_cnt_i(clr), .se_cnt_o(se_cnt), .de_cnt_o(de_cnt)
   );

   ecc_dec_stage #(.K(32), .P0_LSB(1'b0), .CNT_W(2)) dut2 (
      .clk(clk), .rst_n(rst_n), .in_valid_i(in_valid2), .in_ready_o(in_ready2),
      .cw_i(cw2), .out_valid_o(out_valid2), .out_ready_i(out_ready2),
      .data_o(data2), .se_o(se2), .de_o(de2), .syndrome_o(syn2),
      .clr_cnt_i(1'b0), .se_cnt_o(se_cnt2), .de_cnt_o(de_cnt2)
   );

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
      end
   endtask

   // Independent encoder: places data, solves parity so the syndrome is zero.
   function automatic logic [38:0] enc(input logic [31:0] d, input bit p0lsb);
      logic [38:0] p;
      logic [5:0]  s;
      int          k;
      p = '0;
      k = 0;
      for (int i = 1; i <= 38; i++)
         if ((i & (i - 1)) != 0) begin
            p[i] = d[k];
            k++;
         end
      s = '0;
      for (int i = 1; i <= 38; i++)
         if (p[i]) s = s ^ 6'(i);
      for (int j = 0; j < 6; j++) p[1 << j] = s[j];
      p[0] = ^p[38:1];
      return p0lsb ? p : {p[0], p[38:1]};
   endfunction

   function automatic logic [38:0] flip(input logic [38:0] c, input int pos, input bit p0lsb);
      int idx;
      idx = (pos == 0) ? (p0lsb ? 0 : 38) : (p0lsb ? pos : pos - 1);
      c[idx] = ~c[idx];
      return c;
   endfunction

   typedef struct {
      logic [38:0] cw;
      logic [31:0] exp_data;
      logic        exp_se;
      logic        exp_de;
      logic [5:0]  exp_syn;
   } vec_t;

   vec_t vt[9];

   initial begin
      logic [38:0] wq[8];
      logic [31:0] dq[8];
      logic [31:0] prev_d;
      logic        prev_stall;
      int          sent, recv, inflight, exp_se_n, exp_de_n, seen;
      logic        iv, ir, ov, orr;

      // Vector table: {codeword, expected data, se, de, syndrome}
      vt[0] = '{enc(32'hDEADBEEF, 1), 32'hDEADBEEF, 0, 0, 6'd0};
      vt[1] = '{flip(enc(32'hDEADBEEF, 1), 3, 1), 32'hDEADBEEF, 1, 0, 6'd3};
      vt[2] = '{flip(enc(32'hDEADBEEF, 1), 0, 1), 32'hDEADBEEF, 1, 0, 6'd0};
      vt[3] = '{flip(flip(enc(32'hDEADBEEF, 1), 5, 1), 9, 1), 32'hDEADBEFD, 0, 1, 6'd12};
      vt[4] = '{enc(32'hFFFFFFFF, 1), 32'hFFFFFFFF, 0, 0, 6'd0};
      vt[5] = '{flip(enc(32'h12345678, 1), 38, 1), 32'h12345678, 1, 0, 6'd38};
      vt[6] = '{flip(enc(32'h00000000, 1), 1, 1), 32'h00000000, 1, 0, 6'd1};
      vt[7] = '{flip(flip(enc(32'hCAFEF00D, 1), 3, 1), 38, 1), 32'h4AFEF00C, 0, 1, 6'd37};
      vt[8] = '{flip(flip(flip(enc(32'hA5A50F0F, 1), 32, 1), 7, 1), 0, 1), 32'hA5A50F07, 0, 1, 6'd39};

      rst_n = 0; in_valid = 0; out_ready = 1; clr = 0; cw = '0;
      in_valid2 = 0; out_ready2 = 1; cw2 = '0;
      repeat (2) @(negedge clk);
      rst_n = 1;
      @(negedge clk);
      chk("reset out_valid", 64'(out_valid), 64'd0);
      chk("reset in_ready", 64'(in_ready), 64'd1);
      chk("reset data", 64'(data), 64'd0);
      chk("reset cnts", {32'(se_cnt), 32'(de_cnt)}, 64'd0);

      exp_se_n = 0;
      exp_de_n = 0;
      foreach (vt[i]) begin
         in_valid = 1; cw = vt[i].cw;
         @(negedge clk);
         in_valid = 0;
         chk($sformatf("v%0d early valid", i), 64'(out_valid), 64'd0);
         @(negedge clk);
         chk($sformatf("v%0d out_valid", i), 64'(out_valid), 64'd1);
         chk($sformatf("v%0d data", i), 64'(data), 64'(vt[i].exp_data));
         chk($sformatf("v%0d se", i), 64'(se), 64'(vt[i].exp_se));
         chk($sformatf("v%0d de", i), 64'(de), 64'(vt[i].exp_de));
         chk($sformatf("v%0d syndrome", i), 64'(syn), 64'(vt[i].exp_syn));
         exp_se_n += int'(vt[i].exp_se);
         exp_de_n += int'(vt[i].exp_de);
      end
      @(negedge clk);
      chk("table se_cnt", 64'(se_cnt), 64'(exp_se_n));
      chk("table de_cnt", 64'(de_cnt), 64'(exp_de_n));

      // Backpressure stream, out_ready pattern 1,0,0,1,0,0,...
      for (int i = 0; i < 8; i++) begin
         dq[i] = 32'h10000000 + 32'(i) * 32'h01010101;
         wq[i] = (i % 2 == 1) ? flip(enc(dq[i], 1), i + 10, 1) : enc(dq[i], 1);
      end
      sent = 0; recv = 0; inflight = 0; prev_stall = 0; prev_d = '0;
      for (int c = 0; c < 200 && recv < 8; c++) begin
         out_ready = (c % 3 == 0);
         in_valid  = (sent < 8);
         cw        = wq[sent % 8];
         #1;
         iv = in_valid; ir = in_ready; ov = out_valid; orr = out_ready;
         if (prev_stall) chk("stall hold", 64'(data), 64'(prev_d));
         chk("bp in_ready", 64'(ir), 64'(!(inflight == 2 && !orr)));
         if (ov && orr) begin
            chk($sformatf("bp word%0d", recv), 64'(data), 64'(dq[recv]));
            recv++;
            inflight--;
         end
         if (iv && ir) begin
            sent++;
            inflight++;
         end
         prev_stall = ov && !orr;
         prev_d = data;
         @(negedge clk);
      end
      in_valid = 0;
      chk("bp delivered", 64'(recv), 64'd8);

      // Reset with both stages full
      out_ready = 0;
      in_valid = 1; cw = enc(32'h11111111, 1);
      @(negedge clk);
      cw = flip(enc(32'h22222222, 1), 5, 1);
      @(negedge clk);
      in_valid = 0;
      chk("full in_ready", 64'(in_ready), 64'd0);
      chk("full out_valid", 64'(out_valid), 64'd1);
      rst_n = 0;
      @(negedge clk);
      rst_n = 1;
      chk("rst out_valid", 64'(out_valid), 64'd0);
      chk("rst outputs", {32'(data), 8'(syn), 8'(se), 8'(de)}, 64'd0);
      chk("rst cnts", {32'(se_cnt), 32'(de_cnt)}, 64'd0);
      chk("rst in_ready", 64'(in_ready), 64'd1);
      out_ready = 1;
      seen = 0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      chk("no stale words", 64'(seen), 64'd0);

      // Clear beats a coincident increment
      in_valid = 1; cw = flip(enc(32'h0BADF00D, 1), 7, 1);
      @(negedge clk);
      in_valid = 0;
      repeat (2) @(negedge clk);
      chk("pre-clear se_cnt", 64'(se_cnt), 64'd1);
      in_valid = 1; cw = flip(enc(32'h0BADF00D, 1), 9, 1);
      @(negedge clk);
      in_valid = 0;
      @(negedge clk);
      chk("clear cycle valid", 64'(out_valid & out_ready), 64'd1);
      clr = 1;
      @(negedge clk);
      clr = 0;
      chk("clear se_cnt", 64'(se_cnt), 64'd0);

      // CNT_W=2 saturation, p0 at the MSB
      sent = 0; recv = 0;
      for (int c = 0; c < 40 && recv < 5; c++) begin
         in_valid2 = (sent < 5);
         case (sent)
            0: cw2 = flip(enc(32'h01234567, 0), 0, 0);
            1: cw2 = flip(enc(32'h89ABCDEF, 0), 3, 0);
            2: cw2 = flip(enc(32'h55555555, 0), 17, 0);
            3: cw2 = flip(enc(32'hAAAAAAAA, 0), 38, 0);
            default: cw2 = flip(enc(32'h0F0F0F0F, 0), 1, 0);
         endcase
         #1;
         if (out_valid2) begin
            if (recv == 0) chk("p0msb data", 64'(data2), 64'h01234567);
            if (recv == 3) chk("p0msb pos38 data", 64'(data2), 64'hAAAAAAAA);
            chk("p0msb se", 64'(se2), 64'd1);
            recv++;
         end
         if (in_valid2 && in_ready2) sent++;
         @(negedge clk);
      end
      in_valid2 = 0;
      @(negedge clk);
      chk("sat se_cnt", 64'(se_cnt2), 64'd3);
      chk("sat de_cnt", 64'(de_cnt2), 64'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
